// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and decode helpers for the pipeline sequencer.
// Op-type classification functions are the single source of operand/rd usage.
package pipeline_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_LUI,
        OP_AUIPC,
        OP_JAL,
        OP_JALR,
        OP_BRANCH,
        OP_LOAD,
        OP_STORE,
        OP_OPIMM,
        OP_OP,
        OP_MISCMEM,
        OP_SYSTEM,
        OP_ILLEGAL
    } op_type_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_en;
    } ctl_t;

    localparam ctl_t CTL_NORM  = 7'b1101011;
    localparam ctl_t CTL_STALL = 7'b0001111;
    localparam ctl_t CTL_FLUSH = 7'b1111111;
    localparam ctl_t CTL_IDLE  = 7'b0000000;
    localparam ctl_t CTL_RESET = 7'b0010100;

    function automatic logic uses_rs1(op_type_t op);
        case (op)
            OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP: uses_rs1 = 1'b1;
            default: uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(op_type_t op);
        case (op)
            OP_BRANCH, OP_STORE, OP_OP: uses_rs2 = 1'b1;
            default: uses_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(op_type_t op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_OP: writes_rd = 1'b1;
            default: writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Shadow copy of the destination registers held in EX, MEM and WB.
// Produces register-match flags used for load-use detection and forwarding.
module pipe_scoreboard #(
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_load,
    input  logic                 ex_step,
    input  logic                 ex_mem_en,
    input  logic                 mem_wb_en,
    input  logic [NREG_BITS-1:0] id_rd,
    input  logic                 id_writes_rd,
    input  logic                 id_is_load,
    input  logic [NREG_BITS-1:0] id_rs1,
    input  logic [NREG_BITS-1:0] id_rs2,
    output logic                 rs1_ex_hit,
    output logic                 rs1_mem_hit,
    output logic                 rs2_ex_hit,
    output logic                 rs2_mem_hit,
    output logic                 ex_is_load,
    output logic                 pipe_busy
);

    logic                 ex_v;
    logic [NREG_BITS-1:0] ex_rd;
    logic                 ex_ld;
    logic                 mem_v;
    logic [NREG_BITS-1:0] mem_rd;
    logic                 wb_v;
    logic [NREG_BITS-1:0] wb_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v   <= 1'b0;
            ex_rd  <= '0;
            ex_ld  <= 1'b0;
            mem_v  <= 1'b0;
            mem_rd <= '0;
            wb_v   <= 1'b0;
            wb_rd  <= '0;
        end else begin
            // Non-writing ops still occupy a slot but never match a source.
            if (ex_load) begin
                ex_v  <= 1'b1;
                ex_rd <= id_writes_rd ? id_rd : '0;
                ex_ld <= id_is_load;
            end else if (ex_step) begin
                ex_v  <= 1'b0;
                ex_rd <= '0;
                ex_ld <= 1'b0;
            end
            if (ex_mem_en) begin
                mem_v  <= ex_v;
                mem_rd <= ex_rd;
            end
            if (mem_wb_en) begin
                wb_v  <= mem_v;
                wb_rd <= mem_rd;
            end
        end
    end

    assign rs1_ex_hit  = ex_v  && (ex_rd  != '0) && (ex_rd  == id_rs1);
    assign rs2_ex_hit  = ex_v  && (ex_rd  != '0) && (ex_rd  == id_rs2);
    assign rs1_mem_hit = mem_v && (mem_rd != '0) && (mem_rd == id_rs1);
    assign rs2_mem_hit = mem_v && (mem_rd != '0) && (mem_rd == id_rs2);
    assign ex_is_load  = ex_v && ex_ld;
    assign pipe_busy   = ex_v || mem_v || wb_v || (wb_rd == '1 && 1'b0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer: stage enables/flushes, load-use stall, FENCE drain, SYSTEM halt, EX forwarding.
//   state | meaning
//   RUN   | normal issue; load-use stalls and redirects handled here
//   DRAIN | FENCE/SYSTEM waiting in ID for EX/MEM/WB to empty
//   HALT  | SYSTEM retired the pipeline; everything frozen until rst
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  op_type_t             id_op_type,
    input  logic [NREG_BITS-1:0] id_rs1,
    input  logic [NREG_BITS-1:0] id_rs2,
    input  logic [NREG_BITS-1:0] id_rd,
    input  logic                 ex_taken,
    input  logic                 mem_busy,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 if_id_flush,
    output logic                 id_ex_en,
    output logic                 id_ex_flush,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic                 halted
);

    if (XLEN < 32) begin : g_xlen_check
        $error("pipeline_ctrl: XLEN must be at least 32");
    end

    ctrl_state_t state;
    ctrl_state_t state_next;
    ctl_t        ctl;
    logic        halt_set;

    logic rs1_ex_hit, rs1_mem_hit, rs2_ex_hit, rs2_mem_hit;
    logic ex_is_load, pipe_busy;
    logic use1, use2, serialize, load_use, xfer;
    fwd_sel_t fwd_a_next, fwd_b_next;

    assign use1 = id_valid && uses_rs1(id_op_type);
    assign use2 = id_valid && uses_rs2(id_op_type);
    assign serialize = id_valid && (id_op_type == OP_MISCMEM || id_op_type == OP_SYSTEM);
    assign load_use  = ex_is_load && ((use1 && rs1_ex_hit) || (use2 && rs2_ex_hit));

    always_comb begin
        ctl        = CTL_NORM;
        state_next = state;
        halt_set   = 1'b0;
        if (rst) begin
            ctl = CTL_RESET;
        end else if (state == HALT || mem_busy) begin
            ctl = CTL_IDLE;
        end else if (ex_taken) begin
            // Redirect squashes whatever sits in ID, including a pending FENCE/SYSTEM.
            ctl        = CTL_FLUSH;
            state_next = RUN;
        end else if (serialize) begin
            if (pipe_busy) begin
                ctl        = CTL_STALL;
                state_next = DRAIN;
            end else if (id_op_type == OP_SYSTEM) begin
                ctl        = CTL_STALL;
                state_next = HALT;
                halt_set   = 1'b1;
            end else begin
                state_next = RUN;
            end
        end else begin
            state_next = RUN;
            if (load_use) begin
                ctl = CTL_STALL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            state <= state_next;
            if (halt_set) begin
                halted <= 1'b1;
            end
        end
    end

    assign pc_en       = ctl.pc_en;
    assign if_id_en    = ctl.if_id_en;
    assign if_id_flush = ctl.if_id_flush;
    assign id_ex_en    = ctl.id_ex_en;
    assign id_ex_flush = ctl.id_ex_flush;
    assign ex_mem_en   = ctl.ex_mem_en;
    assign mem_wb_en   = ctl.mem_wb_en;

    assign xfer = ctl.id_ex_en && !ctl.id_ex_flush && id_valid;

    // WB needs no forward: the regfile writes before it is read.
    always_comb begin
        fwd_a_next = FWD_RF;
        fwd_b_next = FWD_RF;
        if (use1) begin
            if (rs1_ex_hit) fwd_a_next = FWD_MEM;
            else if (rs1_mem_hit) fwd_a_next = FWD_WB;
        end
        if (use2) begin
            if (rs2_ex_hit) fwd_b_next = FWD_MEM;
            else if (rs2_mem_hit) fwd_b_next = FWD_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else if (ctl.id_ex_en) begin
            fwd_a <= xfer ? fwd_a_next : FWD_RF;
            fwd_b <= xfer ? fwd_b_next : FWD_RF;
        end
    end

    pipe_scoreboard #(
        .NREG_BITS(NREG_BITS)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .ex_load      (xfer),
        .ex_step      (ctl.id_ex_en || ctl.id_ex_flush),
        .ex_mem_en    (ctl.ex_mem_en),
        .mem_wb_en    (ctl.mem_wb_en),
        .id_rd        (id_rd),
        .id_writes_rd (writes_rd(id_op_type)),
        .id_is_load   (id_op_type == OP_LOAD),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .rs1_ex_hit   (rs1_ex_hit),
        .rs1_mem_hit  (rs1_mem_hit),
        .rs2_ex_hit   (rs2_ex_hit),
        .rs2_mem_hit  (rs2_mem_hit),
        .ex_is_load   (ex_is_load),
        .pipe_busy    (pipe_busy)
    );

endmodule
